// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared types and defaults for the round-robin binary-to-BCD converter.
package bcd_convert_arbiter_pkg;

  localparam int IN_W_DEF = 11;
  localparam int NDIG_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_adjust_step.sv
// Double-dabble correction: every BCD nibble >= 5 gets 3 added before the shift.
module bcd_adjust_step
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic [4*NDIG-1:0] bcd_i,
  output logic [4*NDIG-1:0] bcd_o
);

  always_comb begin
    bcd_o = bcd_i;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Sequential binary-to-BCD converter shared by two requesters, one bit per clock.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for req0/req1; round-robin grant and operand capture
//   ST_SHIFT | one adjust-and-shift iteration per cycle, IN_W iterations
//   ST_DONE  | ack/done pulse visible, digits updated, arbiter history saved
module bcd_convert_arbiter
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [IN_W-1:0] bin0,
  input  logic            req1,
  input  logic [IN_W-1:0] bin1,
  output logic            ack0,
  output logic            ack1,
  output logic            busy,
  output logic            done,
  output logic            gnt_id,
  output logic [3:0]      dig0,
  output logic [3:0]      dig1,
  output logic [3:0]      dig2,
  output logic [3:0]      dig3
);

  localparam int BCD_W = 4 * NDIG;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    dig_q, dig_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [SR_W-1:0]     sr_shifted;
  logic                grant_sel;

  bcd_adjust_step #(.NDIG(NDIG)) u_adjust (
    .bcd_i (sr_q[SR_W-1:IN_W]),
    .bcd_o (bcd_adj)
  );

  // The adjusted MSB is shifted out; it is always 0 because 10^NDIG > 2^IN_W.
  assign sr_shifted = {bcd_adj, sr_q[IN_W-1:0]} << 1;

  // On a tie, serve whoever was not served last.
  assign grant_sel = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    count_d = count_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done_d  = 1'b0;
    dig_d   = dig_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sr_d    = {{BCD_W{1'b0}}, (grant_sel ? bin1 : bin0)};
          count_d = CNT_W'(IN_W);
          gnt_d   = grant_sel;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d    = sr_shifted;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          dig_d   = sr_shifted[SR_W-1:IN_W];
          done_d  = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = gnt_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      count_q <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign gnt_id = gnt_q;
  assign dig0   = dig_q[3:0];
  assign dig1   = dig_q[7:4];
  assign dig2   = dig_q[11:8];
  assign dig3   = dig_q[15:12];

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter: latency, arbitration, abort, full sweep.
module tb_bcd_convert_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [10:0] bin0, bin1;
  logic        ack0, ack1, busy, done, gnt_id;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic [15:0] digs;

  int n_checks = 0;
  int n_fail   = 0;
  int unstable = 0;
  logic [15:0] last_res = '0;

  bcd_convert_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .bin0   (bin0),
    .req1   (req1),
    .bin1   (bin1),
    .ack0   (ack0),
    .ack1   (ack1),
    .busy   (busy),
    .done   (done),
    .gnt_id (gnt_id),
    .dig0   (dig0),
    .dig1   (dig1),
    .dig2   (dig2),
    .dig3   (dig3)
  );

  always #5 clk = ~clk;
  assign digs = {dig3, dig2, dig1, dig0};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic do_reset();
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
  endtask

  // Called at a negedge while the DUT is idle; that cycle is cycle 0.
  task automatic convert(input bit sel, input int val, input int exp, input string tag,
                         input bit chk_stable);
    int lat;
    lat = 0;
    if (sel) begin req1 = 1'b1; bin1 = 11'(val); end
    else     begin req0 = 1'b1; bin0 = 11'(val); end
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 && ack1) check({tag, "_both_ack"}, 1, 0);
      if (ack0 || ack1) lat = c;
      else if (chk_stable && digs !== last_res) unstable++;
    end
    check({tag, "_latency"}, lat, 12);
    if (lat != 0) begin
      check({tag, "_ack"}, int'(sel ? ack1 : ack0), 1);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_gnt_id"}, int'(gnt_id), int'(sel));
      check({tag, "_digits"}, int'(digs), exp);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    last_res = digs;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, k, spurious;
    int exp_d[4];
    bin0 = '0;
    bin1 = '0;
    do_reset();
    check("rst_ack0", int'(ack0), 0);
    check("rst_ack1", int'(ack1), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    check("rst_digits", int'(digs), 0);

    convert(1'b0, 2047, 'h2047, "max", 1'b0);
    convert(1'b1, 0,    'h0000, "zero", 1'b0);
    convert(1'b1, 1000, 'h1000, "k1000", 1'b0);
    convert(1'b1, 9,    'h0009, "nine", 1'b0);

    // Simultaneous requests straight after reset: requester 0 wins the tie.
    do_reset();
    req0 = 1'b1; bin0 = 11'd1234;
    req1 = 1'b1; bin1 = 11'd999;
    t0 = 0; t1 = 0;
    for (int c = 1; c <= 40 && t1 == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 && ack1) check("tie_both_ack", 1, 0);
      if (ack0) begin
        t0 = c;
        check("tie_r0_digits", int'(digs), 'h1234);
        check("tie_r0_gnt", int'(gnt_id), 0);
        req0 = 1'b0;
      end
      if (ack1) begin
        t1 = c;
        check("tie_r1_digits", int'(digs), 'h0999);
        check("tie_r1_gnt", int'(gnt_id), 1);
        req1 = 1'b0;
      end
    end
    check("tie_r0_cycle", t0, 12);
    check("tie_r1_cycle", t1, 25);
    @(posedge clk);
    @(negedge clk);

    // Both held: grants alternate; bin0 changes mid-conversion and is ignored.
    exp_d[0] = 'h0500; exp_d[1] = 'h0321; exp_d[2] = 'h0077; exp_d[3] = 'h0321;
    req0 = 1'b1; bin0 = 11'd500;
    req1 = 1'b1; bin1 = 11'd321;
    k = 0;
    for (int c = 1; c <= 70 && k < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 5) bin0 = 11'd77;
      if (ack0 && ack1) check("rr_both_ack", 1, 0);
      if (ack0 || ack1) begin
        check($sformatf("rr%0d_cycle", k), c, 12 + 13 * k);
        check($sformatf("rr%0d_gnt", k), int'(gnt_id), k % 2);
        check($sformatf("rr%0d_ack", k), int'((k % 2) ? ack1 : ack0), 1);
        check($sformatf("rr%0d_digits", k), int'(digs), exp_d[k]);
        k++;
      end
    end
    check("rr_count", k, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset mid-SHIFT aborts the conversion.
    req0 = 1'b1; bin0 = 11'd1500;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    req0  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_digits", int'(digs), 0);
    spurious = 0;
    for (int c = 8; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 || ack1 || done || busy) spurious++;
    end
    check("abort_no_ack", spurious, 0);
    check("abort_digits_hold", int'(digs), 0);
    convert(1'b0, 42, 'h0042, "post_abort", 1'b0);

    for (int v = 0; v < 2048; v++) begin
      convert(1'b0, v, to_bcd(v), $sformatf("sweep%0d", v), 1'b1);
    end
    check("sweep_digits_stable", unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
